// File: rtl/gait_servo_player.sv
// gait_servo_player: plays gait ROM steps out as hobby-servo PWM pulses.
// After reset every joint is held at neutral for a homing period. After that
// the player advances one ROM step per accepted rhythm tick. A new position
// only takes effect at a frame boundary, so a pulse is never cut or stretched.
module gait_servo_player #(
    parameter int CLK_HZ      = 12_000_000,
    parameter int NSERVO      = 12,
    parameter int STEPS       = 64,
    parameter int AW          = 6,
    parameter int FRAME_US    = 20000,
    parameter int LO_US       = 1000,
    parameter int MID_US      = 1500,
    parameter int HI_US       = 2000,
    parameter int HOME_FRAMES = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              run,
    output logic [AW-1:0]     rom_addr,
    input  logic [NSERVO-1:0] rom_data,
    output logic [NSERVO-1:0] servo,
    output logic              homing,
    output logic              frame_start
);

    localparam int CYC_PER_US = CLK_HZ / 1_000_000;
    localparam int FRAME_CYC  = CYC_PER_US * FRAME_US;
    localparam int CW         = $clog2(FRAME_CYC);
    localparam int HW         = (HOME_FRAMES > 1) ? $clog2(HOME_FRAMES) : 1;

    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYC - 1);
    localparam logic [CW-1:0] LO_CYC     = CW'(CYC_PER_US * LO_US);
    localparam logic [CW-1:0] MID_CYC    = CW'(CYC_PER_US * MID_US);
    localparam logic [CW-1:0] HI_CYC     = CW'(CYC_PER_US * HI_US);
    localparam logic [AW-1:0] STEP_LAST  = AW'(STEPS - 1);
    localparam logic [HW-1:0] HOME_LAST  = HW'(HOME_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_HOMING  = 2'd0,
        ST_IDLE    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CW-1:0]     frame_cnt_r;
    logic [HW-1:0]     home_cnt_r, home_cnt_s;
    logic [NSERVO-1:0] pending_r, pending_s;
    logic [NSERVO-1:0] active_r;
    logic [NSERVO-1:0] servo_s;
    logic [AW-1:0]     addr_s;
    logic              homing_s;
    logic              frame_wrap_s;

    assign frame_wrap_s = (frame_cnt_r == FRAME_LAST);

    // Free-running frame counter, wraps every FRAME_CYC clocks in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= {CW{1'b0}};
        end else if (frame_wrap_s) begin
            frame_cnt_r <= {CW{1'b0}};
        end else begin
            frame_cnt_r <= frame_cnt_r + CW'(1);
        end
    end

    // Latch the captured step into the pulse generator only at the frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= {NSERVO{1'b0}};
        end else if (frame_wrap_s) begin
            active_r <= pending_r;
        end else begin
            active_r <= active_r;
        end
    end

    // Step sequencer: homing countdown, tick acceptance, ROM fetch and capture.
    always_comb begin
        state_s    = state_r;
        addr_s     = rom_addr;
        pending_s  = pending_r;
        homing_s   = homing;
        home_cnt_s = home_cnt_r;
        case (state_r)
            ST_HOMING: begin
                if (frame_wrap_s) begin
                    home_cnt_s = home_cnt_r + HW'(1);
                    if (home_cnt_r == HOME_LAST) begin
                        homing_s = 1'b0;
                        state_s  = ST_WAIT;
                    end else begin
                        state_s  = ST_HOMING;
                    end
                end else begin
                    state_s = ST_HOMING;
                end
            end
            ST_IDLE: begin
                if (tick && run) begin
                    addr_s  = (rom_addr == STEP_LAST) ? {AW{1'b0}} : rom_addr + AW'(1);
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                state_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                pending_s = rom_data;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s    = ST_HOMING;
                homing_s   = 1'b1;
                home_cnt_s = {HW{1'b0}};
                addr_s     = {AW{1'b0}};
            end
        endcase
    end

    // Sequencer state and its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_HOMING;
            rom_addr   <= {AW{1'b0}};
            pending_r  <= {NSERVO{1'b0}};
            homing     <= 1'b1;
            home_cnt_r <= {HW{1'b0}};
        end else begin
            state_r    <= state_s;
            rom_addr   <= addr_s;
            pending_r  <= pending_s;
            homing     <= homing_s;
            home_cnt_r <= home_cnt_s;
        end
    end

    // Per-joint pulse comparator: neutral while homing, else HI/LO per position bit.
    always_comb begin
        servo_s = {NSERVO{1'b0}};
        for (int i = 0; i < NSERVO; i++) begin
            if (homing) begin
                servo_s[i] = (frame_cnt_r < MID_CYC);
            end else if (active_r[i]) begin
                servo_s[i] = (frame_cnt_r < HI_CYC);
            end else begin
                servo_s[i] = (frame_cnt_r < LO_CYC);
            end
        end
    end

    // Registered PWM pins and the frame-start strobe (high while frame_cnt == 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            servo       <= {NSERVO{1'b0}};
            frame_start <= 1'b0;
        end else begin
            servo       <= servo_s;
            frame_start <= frame_wrap_s;
        end
    end

endmodule
